// File: rtl/sdrc_buf_pkg.sv
// Shared types and constants for the SDRAM controller application-side buffers.
// The entry record and sizing constants are common to the write and read buffers.
package sdrc_buf_pkg;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction

  localparam int APP_DW = 32;
  localparam int APP_BW = APP_DW / 8;
  localparam int DEPTH  = 8;
  localparam int AW     = clog2(DEPTH);
  localparam int APP_RW = 9;

  typedef struct packed {
    logic [APP_DW-1:0] data;
    logic [APP_BW-1:0] be_n;
    logic              last;
  } wr_entry_t;

  localparam int ENTRY_W = $bits(wr_entry_t);

endpackage

// File: rtl/sdrc_sync_fifo.sv
// Generic first-word-fall-through FIFO: registered storage, head read combinationally
// from the read pointer, occupancy counter that never wraps.
module sdrc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = sdrc_buf_pkg::clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdrc_wr_buf.sv
// Application write-data buffer in front of the SDRAM bus-width converter.
// Adds the upstream handshake, empty-head masking, burst beat counting and sticky error flags.
module sdrc_wr_buf
  import sdrc_buf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [APP_DW-1:0] wb_data,
  input  logic [APP_BW-1:0] wb_be_n,
  input  logic              wb_last,
  output logic [APP_DW-1:0] app_wr_data,
  output logic [APP_BW-1:0] app_wr_en_n,
  input  logic              app_wr_next,
  input  logic              app_last_wr,
  output logic              head_last,
  output logic [AW:0]       buf_count,
  output logic              buf_empty,
  output logic              buf_full,
  output logic [APP_RW-1:0] burst_beats,
  output logic              underrun_err,
  output logic              align_err
);

  wr_entry_t wr_entry;
  wr_entry_t head;
  logic      push;
  logic      pop;

  function automatic logic [APP_RW-1:0] sat_inc(input logic [APP_RW-1:0] value);
    return (&value) ? value : value + APP_RW'(1);
  endfunction

  assign wb_ready = ~buf_full;
  assign push     = wb_valid & wb_ready;
  assign pop      = app_wr_next & ~buf_empty;

  assign wr_entry = '{data: wb_data, be_n: wb_be_n, last: wb_last};

  sdrc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .count (buf_count),
    .empty (buf_empty),
    .full  (buf_full)
  );

  // Stale storage must never reach the converter: an empty head shows masked zeros.
  always_comb begin
    app_wr_data = '0;
    app_wr_en_n = '1;
    head_last   = 1'b0;
    if (!buf_empty) begin
      app_wr_data = head.data;
      app_wr_en_n = head.be_n;
      head_last   = head.last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_beats  <= '0;
      underrun_err <= 1'b0;
      align_err    <= 1'b0;
    end else begin
      if (app_wr_next && buf_empty) begin
        underrun_err <= 1'b1;
      end
      if (pop) begin
        if (app_last_wr != head.last) begin
          align_err <= 1'b1;
        end
        burst_beats <= app_last_wr ? '0 : sat_inc(burst_beats);
      end
    end
  end

endmodule
